// File: rtl/cartridge_bus_mux_pkg.sv
// rtl/cartridge_bus_mux_pkg.sv - shared encodings for the cartridge byte-cycle multiplexer
package cart_bus_pkg;

  // Sequencer states; ST_WAIT is only reachable when CART_WAIT_STATES_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ODD  = 3'd1,
    ST_EVEN = 3'd2,
    ST_ACK  = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  // CPU A0..A2 pattern selecting the >6000..>7FFF cartridge ROM window
  localparam logic [2:0]  CART_WINDOW   = 3'b011;

  // Value returned for accesses that fall outside the window
  localparam logic [15:0] OPEN_BUS_WORD = 16'hFFFF;

endpackage

// File: rtl/cartridge_bus_mux.sv
// rtl/cartridge_bus_mux.sv - 16-bit CPU word to two 8-bit cartridge cycles (odd byte first); optional wait states via CART_WAIT_STATES_EN
module cartridge_bus_mux
  import cart_bus_pkg::*;
`ifdef CART_WAIT_STATES_EN
#(
  parameter int unsigned WAIT_CYCLES = 4
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [0:14] cpu_a,
  input  logic [0:15] cpu_d,
  output logic [0:15] cpu_q,
  output logic        cpu_ack,
  output logic        rom_cs,
  output logic        rom_we,
  output logic [3:15] rom_a,
  output logic [0:7]  rom_d,
  input  logic [0:7]  rom_q
);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [3:14] a_q, a_d;
  logic [0:15] d_q, d_d;
  logic [0:15] q_q, q_d;
  logic        hit_q, hit_d;      // current access actually drives the cartridge port
  logic        cap_hi_q;          // previous cycle was an odd-byte read, rom_q holds it now

`ifdef CART_WAIT_STATES_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  logic [3:0]  cnt_q, cnt_d;
  logic        to_even_q, to_even_d;  // which byte cycle follows the current wait
`endif

  // State and request latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      hit_q     <= 1'b0;
      cap_hi_q  <= 1'b0;
`ifdef CART_WAIT_STATES_EN
      cnt_q     <= '0;
      to_even_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      a_q       <= a_d;
      d_q       <= d_d;
      q_q       <= q_d;
      hit_q     <= hit_d;
      cap_hi_q  <= (state_q == ST_ODD) && !we_q;
`ifdef CART_WAIT_STATES_EN
      cnt_q     <= cnt_d;
      to_even_q <= to_even_d;
`endif
    end
  end

  // Next-state sequencing and read-data assembly
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    a_d       = a_q;
    d_d       = d_q;
    q_d       = q_q;
    hit_d     = hit_q;
`ifdef CART_WAIT_STATES_EN
    cnt_d     = cnt_q;
    to_even_d = to_even_q;
`endif

    // Odd byte arrives the cycle after its rom_cs, whatever state that is
    if (cap_hi_q) begin
      q_d[8:15] = rom_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (cpu_a[0:2] == CART_WINDOW) begin
            we_d  = cpu_we;
            a_d   = cpu_a[3:14];
            d_d   = cpu_d;
            hit_d = 1'b1;
`ifdef CART_WAIT_STATES_EN
            if (WAIT_CYCLES == 0) begin
              state_d = ST_ODD;
            end else begin
              state_d   = ST_WAIT;
              cnt_d     = WAIT_LOAD;
              to_even_d = 1'b0;
            end
`else
            state_d = ST_ODD;
`endif
          end else begin
            hit_d   = 1'b0;
            q_d     = OPEN_BUS_WORD;
            state_d = ST_ACK;
          end
        end
      end
      ST_ODD: begin
`ifdef CART_WAIT_STATES_EN
        if (WAIT_CYCLES == 0) begin
          state_d = ST_EVEN;
        end else begin
          state_d   = ST_WAIT;
          cnt_d     = WAIT_LOAD;
          to_even_d = 1'b1;
        end
`else
        state_d = ST_EVEN;
`endif
      end
      ST_EVEN: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (hit_q && !we_q) begin
          q_d[0:7] = rom_q;
        end
        state_d = ST_IDLE;
      end
`ifdef CART_WAIT_STATES_EN
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = to_even_q ? ST_EVEN : ST_ODD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cartridge port and CPU response decode from state plus latched request
  always_comb begin
    rom_cs  = (state_q == ST_ODD) || (state_q == ST_EVEN);
    rom_we  = rom_cs && we_q;
    rom_a   = '0;
    rom_d   = '0;
    cpu_ack = (state_q == ST_ACK);
    cpu_q   = q_q;
    if (state_q == ST_ODD) begin
      rom_a = {a_q, 1'b1};
      rom_d = d_q[8:15];
    end else if (state_q == ST_EVEN) begin
      rom_a = {a_q, 1'b0};
      rom_d = d_q[0:7];
    end
    // Even byte is still on rom_q during the ack cycle; forward it so the
    // word is complete while cpu_ack is high (it is registered at this edge)
    if (cpu_ack && hit_q && !we_q) begin
      cpu_q = {rom_q, q_q[8:15]};
    end
  end

endmodule

// File: tb/tb_cartridge_bus_mux.sv
// tb/tb_cartridge_bus_mux.sv - self-checking bench for cartridge_bus_mux
module tb_cartridge_bus_mux;

`ifdef CART_WAIT_STATES_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam int LAT_HIT = 3 + 2 * W;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [0:14] cpu_a;
  logic [0:15] cpu_d;
  logic [0:15] cpu_q;
  logic        cpu_ack;
  logic        rom_cs;
  logic        rom_we;
  logic [3:15] rom_a;
  logic [0:7]  rom_d;
  logic [0:7]  rom_q;

  always #5 clk = ~clk;

`ifdef CART_WAIT_STATES_EN
  cartridge_bus_mux #(.WAIT_CYCLES(W)) dut (
`else
  cartridge_bus_mux dut (
`endif
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_ack(cpu_ack),
    .rom_cs(rom_cs), .rom_we(rom_we), .rom_a(rom_a), .rom_d(rom_d),
    .rom_q(rom_q)
  );

  // Cartridge ROM model: registered read data, garbage when not read
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (rom_cs && !rom_we) rom_q <= mem[13'(rom_a)];
    else                   rom_q <= 8'h5A;
  end

  typedef struct packed {
    logic        we;
    logic [12:0] a;
    logic [7:0]  d;
  } rom_cyc_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] d;
  } vec_t;

  rom_cyc_t    rom_exp[$];
  logic [15:0] resp_exp[$];
  logic [15:0] last_q;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Push the byte cycles and the response an access must produce
  task automatic push_exp(input logic we, input logic [15:0] addr, input logic [15:0] d);
    rom_cyc_t c;
    if (addr[15:13] == 3'b011) begin
      c.we = we; c.a = {addr[12:1], 1'b1}; c.d = d[7:0];
      rom_exp.push_back(c);
      c.we = we; c.a = {addr[12:1], 1'b0}; c.d = d[15:8];
      rom_exp.push_back(c);
      if (!we) last_q = {mem[{addr[12:1], 1'b0}], mem[{addr[12:1], 1'b1}]};
    end else begin
      last_q = 16'hFFFF;
    end
    resp_exp.push_back(last_q);
  endtask

  // One clock: advance to the falling edge and score whatever the DUT shows
  task automatic tick();
    rom_cyc_t c;
    @(negedge clk);
    if (rom_cs) begin
      if (rom_exp.size() == 0) begin
        chk("rom_cs_unexpected", 32'(rom_a), 32'hFFFF_FFFF);
      end else begin
        c = rom_exp.pop_front();
        chk("rom_a", 32'(rom_a), 32'(c.a));
        chk("rom_we", 32'(rom_we), 32'(c.we));
        if (c.we) chk("rom_d", 32'(rom_d), 32'(c.d));
      end
    end
    if (cpu_ack) begin
      if (resp_exp.size() == 0) begin
        chk("ack_unexpected", 32'(cpu_q), 32'hFFFF_FFFF);
      end else begin
        chk("cpu_q", 32'(cpu_q), 32'(resp_exp.pop_front()));
      end
    end
  endtask

  // Full access: drive, wait for ack within a bound, check latency and rom_cs placement
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] d,
                        input logic drop_early);
    int k;
    int cs_pos[$];
    logic hit;
    logic acked;
    hit = (addr[15:13] == 3'b011);
    cpu_req = 1'b1; cpu_we = we; cpu_a = addr[15:1]; cpu_d = d;
    push_exp(we, addr, d);
    acked = 1'b0;
    k = 0;
    while (!acked && k < 60) begin
      k++;
      tick();
      if (drop_early && k == 1) cpu_req = 1'b0;
      if (rom_cs) cs_pos.push_back(k);
      if (cpu_ack) acked = 1'b1;
    end
    cpu_req = 1'b0;
    if (!acked) begin
      chk("ack_timeout", 32'(k), 32'hFFFF_FFFF);
    end else begin
      chk("ack_latency", 32'(k), hit ? 32'(LAT_HIT) : 32'd1);
      chk("rom_cs_count", 32'(cs_pos.size()), hit ? 32'd2 : 32'd0);
      if (hit && cs_pos.size() == 2) begin
        chk("rom_cs_first", 32'(cs_pos[0]), 32'(W + 1));
        chk("rom_cs_second", 32'(cs_pos[1]), 32'(2 * W + 2));
      end
    end
    tick();
    chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
  endtask

  vec_t vecs[10];
  int   k1, k2;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h12;
    mem[1] = 8'h34;

    vecs[0] = '{1'b0, 16'h6000, 16'h0000};
    vecs[1] = '{1'b1, 16'h7FFE, 16'hABCD};
    vecs[2] = '{1'b0, 16'hA000, 16'h0000};
    vecs[3] = '{1'b0, 16'h7FFE, 16'h0000};
    vecs[4] = '{1'b1, 16'h6002, 16'h1357};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{1'b0, 16'h8000, 16'h0000};
    vecs[7] = '{1'b0, 16'h5FFE, 16'h0000};
    vecs[8] = '{1'b0, 16'h6ABC, 16'h0000};
    vecs[9] = '{1'b1, 16'hA000, 16'h5555};

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
    last_q = 16'h0000;
    tick(); tick();
    chk("rst_cpu_q", 32'(cpu_q), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_a", 32'(rom_a), 32'd0);
    chk("rst_rom_d", 32'(rom_d), 32'd0);
    reset = 1'b0;
    tick();

    // First read of >6000 must assemble 16'h1234
    chk("model_6000", 32'({mem[0], mem[1]}), 32'h1234);

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].d, 1'b0);
    end

    // Back-to-back reads with cpu_req held through ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 15'(16'h6000 >> 1);
    push_exp(1'b0, 16'h6000, 16'h0000);
    k1 = -1; k2 = -1;
    for (int k = 1; k <= 40 && k2 < 0; k++) begin
      tick();
      if (cpu_ack && k1 < 0) begin
        k1 = k;
        cpu_a = 15'(16'h6002 >> 1);
        push_exp(1'b0, 16'h6002, 16'h0000);
      end else if (cpu_ack) begin
        k2 = k;
      end
    end
    cpu_req = 1'b0;
    chk("b2b_first_ack", 32'(k1), 32'(LAT_HIT));
    chk("b2b_spacing", 32'(k2 - k1), 32'(LAT_HIT + 1));
    tick();

    // Request dropped after one cycle still completes
    access(1'b0, 16'h6100, 16'h0000, 1'b1);

    // Reset while in EVEN: byte cycles already seen, ack must never arrive
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 15'(16'h6000 >> 1);
    push_exp(1'b0, 16'h6000, 16'h0000);
    for (int k = 1; k <= 2 * W + 2; k++) tick();
    chk("pre_rst_in_even", 32'(rom_cs), 32'd1);
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    chk("midrst_rom_cs", 32'(rom_cs), 32'd0);
    chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("midrst_cpu_q", 32'(cpu_q), 32'd0);
    chk("midrst_rom_left", 32'(rom_exp.size()), 32'd0);
    resp_exp.delete();
    last_q = 16'h0000;
    reset = 1'b0;
    tick();
    access(1'b0, 16'h6000, 16'h0000, 1'b0);

    // A write must leave the previous read data in place
    access(1'b1, 16'h6004, 16'h2468, 1'b0);

    chk("rom_queue_drained", 32'(rom_exp.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_exp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
